// File: rtl/hack_memory_map_if.sv
// Purpose: CPU data-memory bus plus keyboard and screen scan-out side channels.
// Ports  : master = CPU/keyboard/display side, slave = memory map.
//          addressM/outM/writeM -> inM; key_data/key_valid -> key_ready;
//          scan_start/scan_ready -> scan_data/scan_valid/scan_last/scan_busy.
interface hack_memory_map_if;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;

  logic [15:0] key_data;
  logic        key_valid;
  logic        key_ready;

  logic        scan_start;
  logic [15:0] scan_data;
  logic        scan_valid;
  logic        scan_last;
  logic        scan_ready;
  logic        scan_busy;

  modport master (
    output addressM, outM, writeM, key_data, key_valid, scan_start, scan_ready,
    input  inM, key_ready, scan_data, scan_valid, scan_last, scan_busy
  );

  modport slave (
    input  addressM, outM, writeM, key_data, key_valid, scan_start, scan_ready,
    output inM, key_ready, scan_data, scan_valid, scan_last, scan_busy
  );
endinterface

// File: rtl/hack_memory_map.sv
// Purpose : Hack data-memory responder: data RAM, screen RAM, keyboard register, screen scan-out.
// Latency : inM is combinational (0 cycles); writes land on the clock edge; first scan word 2 cycles after scan_start.
// Backpr. : key_ready always high after reset; scan_data held stable while scan_ready is low.
// Ports   : clk, reset_n (async, active low), bus (slave modport of hack_memory_map_if).
module hack_memory_map #(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_ADDR     = RAM_WORDS + SCREEN_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  hack_memory_map_if.slave  bus
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);

  localparam logic [14:0]       SCR_BASE = 15'(RAM_WORDS);
  localparam logic [14:0]       KBD      = 15'(KBD_ADDR);
  localparam logic [SCR_AW-1:0] SCR_LAST = SCR_AW'(SCREEN_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } scan_st_t;

  // Storage is never reset; contents are undefined until written.
  logic [15:0] ram_q [RAM_WORDS];
  logic [15:0] scr_q [SCREEN_WORDS];

  logic [15:0] kbd_q;
  logic        key_rdy_q;

  scan_st_t          st_q;
  logic [SCR_AW-1:0] scan_ptr_q;
  logic [15:0]       scan_data_q;
  logic              scan_valid_q;
  logic              scan_last_q;
  logic              scan_busy_q;

  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic              in_ram;
  logic              in_scr;

  // Address decode shared by the read mux and the write port.
  assign ram_idx = bus.addressM[RAM_AW-1:0];
  assign scr_idx = SCR_AW'(bus.addressM - SCR_BASE);
  assign in_ram  = (bus.addressM < SCR_BASE);
  assign in_scr  = !in_ram && (bus.addressM < KBD);

  // CPU write port; the keyboard address and everything above it are read-only.
  always_ff @(posedge clk) begin
    if (bus.writeM) begin
      if (in_ram) begin
        ram_q[ram_idx] <= bus.outM;
      end else if (in_scr) begin
        scr_q[scr_idx] <= bus.outM;
      end
    end
  end

  // Zero-latency read; a same-edge write is not yet visible, so inM shows the old word.
  always_comb begin
    bus.inM = '0;
    if (in_ram) begin
      bus.inM = ram_q[ram_idx];
    end else if (in_scr) begin
      bus.inM = scr_q[scr_idx];
    end else if (bus.addressM == KBD) begin
      bus.inM = kbd_q;
    end
  end

  // Keyboard register: latches every accepted event, 0 meaning all keys released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kbd_q     <= '0;
      key_rdy_q <= 1'b0;
    end else begin
      key_rdy_q <= 1'b1;
      if (bus.key_valid && key_rdy_q) begin
        kbd_q <= bus.key_data;
      end
    end
  end

  // Scan-out FSM: one registered screen read per word, then hold until accepted.
  // The screen read here samples the array before any same-edge CPU write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q         <= S_IDLE;
      scan_ptr_q   <= '0;
      scan_data_q  <= '0;
      scan_valid_q <= 1'b0;
      scan_last_q  <= 1'b0;
      scan_busy_q  <= 1'b0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (bus.scan_start) begin
            st_q        <= S_FETCH;
            scan_ptr_q  <= '0;
            scan_busy_q <= 1'b1;
          end
        end
        S_FETCH: begin
          scan_data_q  <= scr_q[scan_ptr_q];
          scan_valid_q <= 1'b1;
          scan_last_q  <= (scan_ptr_q == SCR_LAST);
          st_q         <= S_HOLD;
        end
        S_HOLD: begin
          if (scan_valid_q && bus.scan_ready) begin
            scan_valid_q <= 1'b0;
            if (scan_last_q) begin
              st_q        <= S_IDLE;
              scan_last_q <= 1'b0;
              scan_busy_q <= 1'b0;
            end else begin
              scan_ptr_q <= scan_ptr_q + SCR_AW'(1);
              st_q       <= S_FETCH;
            end
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign bus.key_ready  = key_rdy_q;
  assign bus.scan_data  = scan_data_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.scan_last  = scan_last_q;
  assign bus.scan_busy  = scan_busy_q;

endmodule

// File: tb/tb_hack_memory_map.sv
// Purpose : Self-checking bench for hack_memory_map (CPU port, keyboard, screen scan-out).
// Latency : Inputs driven 1 time unit after the rising edge; scan handshakes sampled on the falling edge.
// Backpr. : Scan scoreboard is filled when a scan is started and drained on each accepted word.
module tb_hack_memory_map;

  localparam int SCR_N = 8192;

  typedef struct {
    logic [15:0] dat;
    logic        last;
  } sb_ent_t;

  logic clk = 1'b0;
  logic reset_n;

  hack_memory_map_if bus();

  hack_memory_map dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int      n_chk  = 0;
  int      n_fail = 0;
  int      words_seen = 0;
  sb_ent_t sb_q[$];
  logic [15:0] scr_m [SCR_N];
  bit      found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [14:0] a, input logic [15:0] d);
    bus.addressM = a;
    bus.outM     = d;
    bus.writeM   = 1'b1;
    tick();
    bus.writeM   = 1'b0;
  endtask

  task automatic cpu_rd_chk(input string tag, input logic [14:0] a, input logic [15:0] exp);
    bus.addressM = a;
    #1;
    chk(tag, 32'(bus.inM), 32'(exp));
  endtask

  task automatic key_event(input logic [15:0] k);
    bus.key_data  = k;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
  endtask

  function automatic logic [15:0] scr_pat(input int i);
    if (i == 0)         return 16'hFFFF;
    if (i == SCR_N - 1) return 16'h8001;
    return 16'(i * 37) ^ 16'hA5C3;
  endfunction

  task automatic push_scan();
    for (int i = 0; i < SCR_N; i++) begin
      sb_q.push_back('{dat: scr_m[i], last: (i == SCR_N - 1)});
    end
  endtask

  task automatic wait_scan_done(input string tag);
    found = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      tick();
      if (!bus.scan_busy) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(found), 32'd1);
    chk({tag, "_words"}, 32'(words_seen), 32'(SCR_N));
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_vld_low"}, 32'(bus.scan_valid), 32'd0);
    chk({tag, "_last_low"}, 32'(bus.scan_last), 32'd0);
  endtask

  // Scoreboard drain: every accepted scan word must match the next expected entry.
  always @(negedge clk) begin
    sb_ent_t e;
    if (reset_n && bus.scan_valid && bus.scan_ready) begin
      if (sb_q.size() == 0) begin
        chk("scan_extra_word", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("scan_dat", 32'(bus.scan_data), 32'(e.dat));
        chk("scan_last", 32'(bus.scan_last), 32'(e.last));
      end
      words_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    bus.addressM   = '0;
    bus.outM       = '0;
    bus.writeM     = 1'b0;
    bus.key_data   = '0;
    bus.key_valid  = 1'b0;
    bus.scan_start = 1'b0;
    bus.scan_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_scan_valid", 32'(bus.scan_valid), 32'd0);
    chk("rst_scan_last", 32'(bus.scan_last), 32'd0);
    chk("rst_scan_busy", 32'(bus.scan_busy), 32'd0);
    chk("rst_scan_data", 32'(bus.scan_data), 32'd0);
    chk("rst_key_ready", 32'(bus.key_ready), 32'd0);
    cpu_rd_chk("rst_kbd", 15'h6000, 16'h0000);

    reset_n = 1'b1;
    tick();
    chk("key_ready_after_rst", 32'(bus.key_ready), 32'd1);

    // Data RAM: same-cycle read shows the old word, next cycle the new one.
    cpu_wr(15'd5, 16'h1111);
    bus.addressM = 15'd5;
    bus.outM     = 16'h1234;
    bus.writeM   = 1'b1;
    #1;
    chk("ram_same_cycle_old", 32'(bus.inM), 32'h1111);
    tick();
    bus.writeM = 1'b0;
    #1;
    chk("ram_next_cycle_new", 32'(bus.inM), 32'h1234);
    cpu_wr(15'h3FFF, 16'hCAFE);
    cpu_rd_chk("ram_top", 15'h3FFF, 16'hCAFE);
    cpu_rd_chk("ram_addr5_kept", 15'd5, 16'h1234);

    // Keyboard register is read-only from the CPU side.
    cpu_wr(15'h6000, 16'hBEEF);
    cpu_rd_chk("kbd_write_ignored", 15'h6000, 16'h0000);
    bus.key_data  = 16'h0041;
    bus.key_valid = 1'b1;
    #1;
    chk("kbd_before_edge", 32'(bus.inM), 32'h0000);
    tick();
    bus.key_valid = 1'b0;
    #1;
    chk("kbd_press", 32'(bus.inM), 32'h0041);
    tick();
    chk("kbd_hold", 32'(bus.inM), 32'h0041);
    key_event(16'h0000);
    cpu_rd_chk("kbd_release", 15'h6000, 16'h0000);
    cpu_rd_chk("unmapped_7fff", 15'h7FFF, 16'h0000);
    cpu_rd_chk("unmapped_6001", 15'h6001, 16'h0000);

    // Fill the whole screen so every scanned word has a known value.
    for (int i = 0; i < SCR_N; i++) begin
      scr_m[i] = scr_pat(i);
      cpu_wr(15'(16384 + i), scr_m[i]);
    end
    cpu_rd_chk("scr_first", 15'h4000, 16'hFFFF);
    cpu_rd_chk("scr_last", 15'h5FFF, 16'h8001);

    // Scan 1: full speed, stalled on word 3, with an ignored restart pulse.
    words_seen     = 0;
    bus.scan_ready = 1'b1;
    bus.scan_start = 1'b1;
    push_scan();
    tick();
    bus.scan_start = 1'b0;
    chk("scan1_busy", 32'(bus.scan_busy), 32'd1);
    chk("scan1_not_yet_vld", 32'(bus.scan_valid), 32'd0);
    tick();
    chk("scan1_first_vld", 32'(bus.scan_valid), 32'd1);
    chk("scan1_first_dat", 32'(bus.scan_data), 32'hFFFF);

    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.scan_valid && words_seen == 3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("stall_reach_word3", 32'(found), 32'd1);
    bus.scan_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.scan_start = (c == 0);
      tick();
      chk("stall_vld", 32'(bus.scan_valid), 32'd1);
      chk("stall_dat", 32'(bus.scan_data), 32'(scr_m[3]));
      chk("stall_busy", 32'(bus.scan_busy), 32'd1);
    end
    bus.scan_start = 1'b0;
    chk("stall_no_accept", 32'(words_seen), 32'd3);
    bus.scan_ready = 1'b1;
    wait_scan_done("scan1");

    // Scan 2: reset lands while word 100 is presented.
    key_event(16'h0055);
    cpu_rd_chk("kbd_pre_rst", 15'h6000, 16'h0055);
    words_seen     = 0;
    bus.scan_start = 1'b1;
    push_scan();
    tick();
    bus.scan_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (bus.scan_valid && words_seen == 100) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("scan2_reach_word100", 32'(found), 32'd1);
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_vld", 32'(bus.scan_valid), 32'd0);
    chk("midrst_busy", 32'(bus.scan_busy), 32'd0);
    chk("midrst_last", 32'(bus.scan_last), 32'd0);
    chk("midrst_key_ready", 32'(bus.key_ready), 32'd0);
    cpu_rd_chk("midrst_kbd", 15'h6000, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();

    // Scan 3: must restart from word 0 and run to completion.
    words_seen     = 0;
    bus.scan_start = 1'b1;
    push_scan();
    tick();
    bus.scan_start = 1'b0;
    tick();
    chk("scan3_first_vld", 32'(bus.scan_valid), 32'd1);
    chk("scan3_first_dat", 32'(bus.scan_data), 32'hFFFF);
    wait_scan_done("scan3");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
